// File: rtl/e_mdu_ctrl.sv
// Purpose : E-stage multiply/divide sequencer; owns HI/LO and models fixed MULT/DIV latency.
// Latency : result latched at issue, committed MULT_CYC / DIV_CYC cycles later (HI/LO and busy fall together).
// Backpressure: no handshake; E_Busy plus MD_Stall hold D/F while an operation is in flight or issuing.
//
// Ports:
//   clk, reset (async, active-low)
//   E_MDOp   4-bit op: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others none
//   E_A/E_B  forwarded rs/rt operands
//   Req      exception/interrupt cancels the E-stage instruction this cycle
//   D_isMD   D stage holds an MD-class instruction
//   E_MDRe   MFHI/MFLO read data (combinational)
//   E_Busy   operation in flight
//   MD_Stall stall request to D/F
//   HI/LO    architectural registers
module e_mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  input  logic        D_isMD,
  output logic [31:0] E_MDRe,
  output logic        E_Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_dz;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic        is_mul;
  logic        is_div;
  logic        start;
  logic        div_zero;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_mul   = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
  assign is_div   = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
  assign E_Busy   = (count != '0);
  assign start    = (is_mul || is_div) && !E_Busy && !Req;
  assign div_zero = (E_B == 32'd0);

  // One 64x64 multiplier serves both flavours: the low 64 bits of the
  // product of sign-extended operands are the exact signed result.
  assign a_ext = (E_MDOp == OP_MULT) ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
  assign b_ext = (E_MDOp == OP_MULT) ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
  assign prod  = a_ext * b_ext;

  // Signed division runs on magnitudes through the unsigned divider.
  // |0x80000000| is 0x80000000 as unsigned, so 0x80000000 / -1 yields
  // quotient 0x80000000 (after negation) and remainder 0 with no overflow case.
  assign div_signed = (E_MDOp == OP_DIV);
  assign a_neg      = div_signed && E_A[31];
  assign b_neg      = div_signed && E_B[31];
  assign a_mag      = a_neg ? (32'd0 - E_A) : E_A;
  assign b_mag      = b_neg ? (32'd0 - E_B) : E_B;
  // Divisor forced to 1 on divide-by-zero only to keep the datapath defined;
  // the result is discarded at commit.
  assign b_safe     = div_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  assign res_hi = is_div ? rem  : prod[63:32];
  assign res_lo = is_div ? quot : prod[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_dz <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      if (start) begin
        pending_hi <= res_hi;
        pending_lo <= res_lo;
        pending_dz <= is_div && div_zero;
        count      <= is_div ? DIV_CNT : MULT_CNT;
      end else if (E_Busy) begin
        // In-flight work was issued by an older instruction, so Req does
        // not cancel it; it always runs to its commit edge.
        count <= count - CNT_ONE;
        if ((count == CNT_ONE) && !pending_dz) begin
          hi_q <= pending_hi;
          lo_q <= pending_lo;
        end
      end
      // Moves only land when idle; count is zero then, so no commit races them.
      if (!E_Busy && !Req) begin
        if (E_MDOp == OP_MTHI) hi_q <= E_A;
        if (E_MDOp == OP_MTLO) lo_q <= E_A;
      end
    end
  end

  always_comb begin
    E_MDRe = 32'd0;
    case (E_MDOp)
      OP_MFHI: E_MDRe = hi_q;
      OP_MFLO: E_MDRe = lo_q;
      default: E_MDRe = 32'd0;
    endcase
  end

  // Stalling during the issue cycle keeps a dependent MD op out of E until
  // the busy flag is already visible.
  assign MD_Stall = D_isMD && (E_Busy || is_mul || is_div);

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
module tb_e_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        Req;
  logic        D_isMD;
  logic [31:0] E_MDRe;
  logic        E_Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDOp   (E_MDOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .Req      (Req),
    .D_isMD   (D_isMD),
    .E_MDRe   (E_MDRe),
    .E_Busy   (E_Busy),
    .MD_Stall (MD_Stall),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } sb_t;

  localparam int NV = 16;
  vec_t vt [NV];
  sb_t  sb_q [$];

  int errors = 0;
  int checks = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts busy cycles (bounded) and busy cycles in which the stall dropped.
  task automatic wait_idle(output int n, output int stall_low);
    n = 0;
    stall_low = 0;
    while (E_Busy && n < 64) begin
      if (!MD_Stall) stall_low++;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    E_MDOp = op; E_A = a; E_B = b; Req = req;
    @(posedge clk);
    #1;
    E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0; Req = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int n);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_busy"}, 32'(n), 32'(e.busy));
      check({tag, "_hi"}, HI, e.hi);
      check({tag, "_lo"}, LO, e.lo);
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int sl;
    reset = 1'b0; E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0; Req = 1'b0; D_isMD = 1'b1;

    vt[0]  = '{4'd0,  32'h0,        32'h0,        32'h00000000, 32'h00000000, 0};
    vt[1]  = '{4'd1,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vt[2]  = '{4'd2,  32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vt[3]  = '{4'd3,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[4]  = '{4'd4,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[5]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vt[6]  = '{4'd4,  32'h7,        32'h2,        32'h00000001, 32'h00000003, 10};
    vt[7]  = '{4'd5,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h00000003, 0};
    vt[8]  = '{4'd6,  32'hCAFEBABE, 32'h0,        32'hA5A5A5A5, 32'hCAFEBABE, 0};
    vt[9]  = '{4'd3,  32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vt[10] = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vt[11] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[12] = '{4'd3,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFFE, 32'h00000001, 10};
    vt[13] = '{4'd12, 32'h1234,     32'h5678,     32'hFFFFFFFE, 32'h00000001, 0};
    vt[14] = '{4'd4,  32'hFFFFFFFF, 32'hA,        32'h00000005, 32'h19999999, 10};
    vt[15] = '{4'd1,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};

    // Reset state
    #2;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(E_Busy), 32'd0);
    check("rst_stall", 32'(MD_Stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven single operations with D holding an MD op throughout
    for (int i = 0; i < NV; i++) begin
      sb_q.push_back('{vt[i].exp_hi, vt[i].exp_lo, vt[i].exp_busy});
      D_isMD = 1'b1;
      E_MDOp = vt[i].op; E_A = vt[i].a; E_B = vt[i].b; Req = 1'b0;
      #1;
      check($sformatf("v%0d_stall_issue", i), 32'(MD_Stall),
            32'((vt[i].op >= 4'd1) && (vt[i].op <= 4'd4)));
      @(posedge clk); #1;
      E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
      wait_idle(n, sl);
      finish_op($sformatf("v%0d", i), n);
      check($sformatf("v%0d_stall_busy", i), 32'(sl), 32'd0);
      check($sformatf("v%0d_stall_after", i), 32'(MD_Stall), 32'd0);
      E_MDOp = 4'd7; #1;
      check($sformatf("v%0d_mfhi", i), E_MDRe, model_hi);
      E_MDOp = 4'd8; #1;
      check($sformatf("v%0d_mflo", i), E_MDRe, model_lo);
      E_MDOp = 4'd0;
    end
    D_isMD = 1'b0;
    @(posedge clk); #1;

    // MTHI cancelled by Req, then accepted
    issue(4'd5, 32'h12345678, 32'd0, 1'b1);
    check("mthi_req_hi", HI, model_hi);
    issue(4'd5, 32'h12345678, 32'd0, 1'b0);
    model_hi = 32'h12345678;
    check("mthi_hi", HI, model_hi);

    // DIV cancelled by Req never starts
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    check("div_req_busy", 32'(E_Busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("div_req_hi", HI, model_hi);
    check("div_req_lo", LO, model_lo);

    // Req during busy cycle 3 does not cancel the in-flight DIV: 100/7 = 14 r 2
    sb_q.push_back('{32'd2, 32'd14, 10});
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (E_Busy && n < 64) begin
      n++;
      Req = (n == 3);
      check($sformatf("req_mid_hold%0d", n), HI, model_hi);
      @(posedge clk); #1;
    end
    Req = 1'b0;
    finish_op("req_mid", n);

    // MULT/MTHI/MTLO during a DIV are ignored: 100/9 = 11 r 1
    sb_q.push_back('{32'd1, 32'd11, 10});
    issue(4'd3, 32'd100, 32'd9, 1'b0);
    n = 0;
    while (E_Busy && n < 64) begin
      n++;
      case (n)
        2:       begin E_MDOp = 4'd1; E_A = 32'd3;      E_B = 32'd5; end
        5:       begin E_MDOp = 4'd5; E_A = 32'hDEAD;   E_B = 32'd0; end
        6:       begin E_MDOp = 4'd6; E_A = 32'hBEEF;   E_B = 32'd0; end
        default: begin E_MDOp = 4'd0; E_A = 32'd0;      E_B = 32'd0; end
      endcase
      @(posedge clk); #1;
    end
    E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
    finish_op("ovl", n);
    repeat (6) @(posedge clk);
    #1;
    check("ovl_no_late_busy", 32'(E_Busy), 32'd0);
    check("ovl_no_late_lo", LO, model_lo);

    // Async reset at busy cycle 4 discards the DIV
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(E_Busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(E_Busy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst_post_busy", 32'(E_Busy), 32'd0);
    check("rst_post_hi", HI, 32'd0);
    check("rst_post_lo", LO, 32'd0);

    // Operation after reset: 3 * -5 = -15
    sb_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    issue(4'd1, 32'd3, 32'hFFFFFFFB, 1'b0);
    wait_idle(n, sl);
    finish_op("post_rst_mult", n);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
